// File: rtl/multiplier_control.sv
// rtl/multiplier_control.sv - sequencing FSM for an N-step shift-add multiplier
module multiplier_control #(
    parameter int N = 4
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic in_valid_i,
    output logic in_ready_o,
    output logic out_valid_o,
    input  logic out_ready_i,
    input  logic multiplier_lsb_i,
    input  logic count_is_zero_i,
    output logic do_load_o,
    output logic do_preset_o,
    output logic do_add_o,
    output logic do_shift_o,
    output logic do_decrement_o,
    output logic busy_o,
    output logic step_error_o
);
    localparam int WW = $clog2(N + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(N - 1);

    typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

    state_t        state_q, state_d;
    logic [WW-1:0] wd_q, wd_d;
    logic          err_q, err_d;
    logic          in_idle, in_step, in_done, overrun;

    assign in_idle = (state_q == IDLE);
    assign in_step = (state_q == STEP);
    assign in_done = (state_q == DONE);
    // Last permitted step cycle reached but the counter never hit zero.
    assign overrun = in_step && !count_is_zero_i && (wd_q == WD_LAST);

    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    state_d = STEP;
                    wd_d    = '0;
                end
            end
            STEP: begin
                wd_d = wd_q + WW'(1);
                if (count_is_zero_i || overrun) begin
                    state_d = DONE;
                end
                if (overrun) begin
                    err_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end

    // Everything is gated by reset so nothing leaks out while it is held.
    assign in_ready_o     = !reset_i && in_idle;
    assign out_valid_o    = !reset_i && in_done;
    assign busy_o         = !reset_i && !in_idle;
    assign do_load_o      = !reset_i && in_idle && in_valid_i;
    assign do_preset_o    = !reset_i && in_idle && in_valid_i;
    assign do_shift_o     = !reset_i && in_step;
    assign do_add_o       = !reset_i && in_step && multiplier_lsb_i;
    assign do_decrement_o = !reset_i && in_step && !count_is_zero_i && !overrun;
    assign step_error_o   = err_q;
endmodule

// File: tb/tb_multiplier_control.sv
// tb/tb_multiplier_control.sv - randomized bench for multiplier_control against a transaction model
module tb_multiplier_control;
    localparam int N = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0, out_ready = 1'b0, multiplier_lsb = 1'b0, count_is_zero = 1'b0;
    logic in_ready, out_valid, do_load, do_preset, do_add, do_shift, do_decrement, busy, step_error;

    multiplier_control #(.N(N)) dut (
        .clock_i(clock), .reset_i(reset),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .multiplier_lsb_i(multiplier_lsb), .count_is_zero_i(count_is_zero),
        .do_load_o(do_load), .do_preset_o(do_preset), .do_add_o(do_add),
        .do_shift_o(do_shift), .do_decrement_o(do_decrement),
        .busy_o(busy), .step_error_o(step_error)
    );

    always #5 clock = ~clock;

    int nvec = 0;
    int nerr = 0;

    // Operation model: k = 0 idle, 1..steps = step number within the operation, steps+1 = done.
    // mode 0: counter reaches zero on step N; mode 1: counter stuck non-zero; mode 2: zero on step 1.
    int           k = 0;
    int           steps = N;
    int           mode = 0;
    logic [N-1:0] op = '0;
    bit           err_exp = 1'b0;
    logic [N-1:0] next_op = '0;
    int           next_mode = 0;
    int           cyc = 0;
    int           accepts[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"}, {in_ready, out_valid, busy, do_load, do_preset, do_add, do_shift, do_decrement}, 8'h00);
    endtask

    // One clock cycle: drive at the falling edge, check, then advance the model past the rising edge.
    task automatic tick(input bit iv, input bit ordy);
        bit e_ir, e_ov, e_busy, e_load, e_shift, e_add, e_dec;
        in_valid  = iv;
        out_ready = ordy;
        if (k >= 1 && k <= steps) begin
            multiplier_lsb = op[k-1];
            count_is_zero  = (mode == 0) ? (k == N) : (mode == 2);
        end else begin
            multiplier_lsb = 1'($urandom);
            count_is_zero  = 1'($urandom);
        end
        #1;
        {e_ir, e_ov, e_busy, e_load, e_shift, e_add, e_dec} = '0;
        if (k == 0) begin
            e_ir   = 1'b1;
            e_load = iv;
        end else if (k <= steps) begin
            e_busy  = 1'b1;
            e_shift = 1'b1;
            e_add   = op[k-1];
            e_dec   = (k < steps);
        end else begin
            e_busy = 1'b1;
            e_ov   = 1'b1;
        end
        check("in_ready", in_ready, e_ir);
        check("out_valid", out_valid, e_ov);
        check("busy", busy, e_busy);
        check("do_load", do_load, e_load);
        check("do_preset", do_preset, e_load);
        check("do_shift", do_shift, e_shift);
        check("do_add", do_add, e_add);
        check("do_decrement", do_decrement, e_dec);
        check("step_error", step_error, err_exp);
        if (iv && in_ready) accepts.push_back(cyc);
        @(posedge clock);
        if (k == 0) begin
            if (iv) begin
                op    = next_op;
                mode  = next_mode;
                steps = (mode == 2) ? 1 : N;
                k     = 1;
            end
        end else if (k <= steps) begin
            if (k == steps && mode == 1) err_exp = 1'b1;
            k++;
        end else if (ordy) begin
            k = 0;
        end
        cyc++;
        @(negedge clock);
    endtask

    initial begin
        // Reset held: outputs forced low even with in_valid offered.
        @(negedge clock);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check_all_zero("reset_hold");
        check("reset_step_error", step_error, 1'b0);
        @(negedge clock);
        reset = 1'b0;

        // Directed operation with multiplier 1011, held in DONE for 10 cycles.
        next_op = 4'b1011;
        next_mode = 0;
        tick(1, 0);
        for (int i = 0; i < N; i++) tick(1, 1);
        for (int i = 0; i < 10; i++) tick(1, 0);
        tick(0, 1);
        tick(0, 0);

        // Back-to-back: in_valid held high and out_ready high.
        accepts.delete();
        for (int i = 0; i < 30; i++) begin
            next_op = N'($urandom);
            tick(1, 1);
        end
        for (int i = 1; i < accepts.size(); i++)
            check("accept_period", accepts[i] - accepts[i-1], N + 2);
        while (k != 0) tick(0, 1);

        // Stuck counter: overrun sets a sticky error that survives the next operation.
        next_mode = 1;
        next_op = N'($urandom);
        tick(1, 0);
        for (int i = 0; i < N + 2; i++) tick(0, 0);
        tick(0, 1);
        next_mode = 0;
        tick(1, 1);
        while (k != 0) tick(0, 1);

        // Counter already zero on the first step.
        next_mode = 2;
        tick(1, 0);
        tick(0, 1);
        tick(0, 1);
        next_mode = 0;

        // Reset during the second step cycle.
        tick(1, 0);
        tick(0, 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        check_all_zero("reset_mid_step");
        check("reset_mid_error", step_error, 1'b0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        k = 0;
        err_exp = 1'b0;
        tick(0, 1);
        tick(0, 1);

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            int r;
            r = $urandom_range(0, 19);
            next_mode = (r == 0) ? 1 : (r < 4) ? 2 : 0;
            next_op = N'($urandom);
            tick(1'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/multiplier_control.md
MULTIPLIER_CONTROL -- requirements
Module: multiplier_control

Interface
REQ-001 Parameter N, default 4: datapath width in bits; the number of shift-add steps per multiplication; N >= 2.
REQ-002 clock  input  1  single clock for the block; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  upstream offers a new operand pair.
REQ-005 in_ready  output  1  block accepts operands; a transfer occurs on a rising edge where in_valid & in_ready.
REQ-006 out_valid  output  1  product in datapath is complete and held.
REQ-007 out_ready  input  1  downstream accepts the product; a transfer occurs on a rising edge where out_valid & out_ready.
REQ-008 multiplier_lsb  input  1  current LSB of the datapath multiplier shift register.
REQ-009 count_is_zero  input  1  step counter value equals zero (counter's is_zero).
REQ-010 do_load  output  1  datapath loads operands and clears the accumulator.
REQ-011 do_preset  output  1  step counter loads N-1.
REQ-012 do_add  output  1  accumulator adds the multiplicand this cycle.
REQ-013 do_shift  output  1  accumulator/multiplier pair shifts right by one.
REQ-014 do_decrement  output  1  step counter decrements by one.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 step_error  output  1  sticky flag: step sequence overran N cycles.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, STEP and DONE, held in a registered state variable.
REQ-018 IDLE: in_ready=1; on in_valid, do_load=1 and do_preset=1 combinationally in the same cycle; next state STEP.
REQ-019 IDLE without in_valid: all strobes 0; stay in IDLE.
REQ-020 STEP: do_shift=1 every cycle; do_add=multiplier_lsb; in_ready=0; out_valid=0.
REQ-021 STEP with count_is_zero=0: do_decrement=1; stay in STEP.
REQ-022 STEP with count_is_zero=1: do_decrement=0 (no counter wrap); next state DONE.
REQ-023 A nominal operation SHALL spend exactly N cycles in STEP: accept at edge t, STEP cycles t+1..t+N, out_valid high from cycle t+N+1.
REQ-024 The block SHALL contain an internal watchdog counter, width $clog2(N+1), cleared on accept and incremented each STEP cycle.
REQ-025 If the watchdog reaches N in STEP while count_is_zero=0, then step_error SHALL set (sticky until reset), do_decrement=0, and the next state SHALL be DONE.
REQ-026 DONE: out_valid=1; all strobes 0; in_ready=0; out_valid and datapath SHALL be held stable until out_ready.
REQ-027 DONE with out_ready=1: next state IDLE; a new operand pair is accepted no earlier than the following cycle (minimum period N+2 cycles).
REQ-028 multiplier_lsb and count_is_zero SHALL be ignored outside STEP; out_ready SHALL be ignored outside DONE; in_valid SHALL be ignored outside IDLE.
REQ-029 do_preset and do_decrement SHALL never be asserted in the same cycle.
REQ-030 All outputs SHALL be pure functions of the registered state, the watchdog and current inputs, with no combinational path from out_ready to in_ready.

Reset
REQ-031 While reset=1, the state SHALL be IDLE, the watchdog 0 and step_error 0; in_ready, out_valid, busy and all strobes SHALL be forced to 0 regardless of other inputs.
REQ-032 Assertion of reset mid-STEP or in DONE SHALL take effect immediately (asynchronously) and discard the operation without producing out_valid.
REQ-033 After reset deasserts, in_ready SHALL be 1 in the first cycle.

Verification
REQ-034 N=4; in_valid pulse, counter model 3->0, multiplier=4'b1011 -> do_load/do_preset in the accept cycle; 4 STEP cycles with do_shift=1111, do_add=1,1,0,1, do_decrement=1,1,1,0; out_valid on cycle 5.
REQ-035 out_ready held low for 10 cycles in DONE -> out_valid stays 1, no strobes, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-036 in_valid held high continuously with out_ready=1 -> one accept every 6 cycles (N+2), never during STEP/DONE.
REQ-037 count_is_zero stuck at 0 -> after 4 STEP cycles step_error=1, DONE entered, do_decrement=0 on the 4th cycle; step_error persists through later operations until reset.
REQ-038 reset pulsed during the 2nd STEP cycle -> strobes and busy drop immediately, out_valid never asserts, in_ready=1 the first cycle after release.
REQ-039 count_is_zero=1 on the first STEP cycle -> single STEP cycle, do_decrement=0, DONE next cycle, step_error=0.
